// File: rtl/ps2_scancode_fifo.sv
// PS/2 keyboard receiver: pin sync, 11-bit deframing, E0/F0 prefix assembly
// and a first-word-fall-through FIFO of 32-bit scancodes.
module ps2_scancode_fifo #(
  parameter int FIFO_DEPTH   = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_BITS = 20,
  parameter int CHECK_PARITY = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          clr_errors,
  output logic [31:0]                   code,
  output logic                          code_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TIMEOUT_BITS-1:0] TO_LIMIT =
    {1'b1, {(TIMEOUT_BITS-1){1'b0}}};

  logic [SYNC_STAGES-1:0]  ck_sync_q, dt_sync_q;
  logic                    ck_prev_q;
  logic                    ck_s, dt_s, fall;

  logic [10:0]             frame_q, frame_d;
  logic [3:0]              bitcnt_q, bitcnt_d;
  logic [TIMEOUT_BITS-1:0] idle_q, idle_d;
  logic [31:0]             acc_q, acc_d;
  logic                    err_d, frame_err_q;
  logic [7:0]              rx_byte;
  logic                    frame_ok, is_prefix;
  logic                    push;
  logic [31:0]             push_code;

  logic [31:0]             mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wptr_q, rptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    full, pop, wr;

  assign ck_s = ck_sync_q[SYNC_STAGES-1];
  assign dt_s = dt_sync_q[SYNC_STAGES-1];
  assign fall = ck_prev_q & ~ck_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ck_sync_q <= '1;
      dt_sync_q <= '1;
      ck_prev_q <= 1'b1;
    end else begin
      ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dt_sync_q <= {dt_sync_q[SYNC_STAGES-2:0], ps2_data};
      ck_prev_q <= ck_s;
    end
  end

  // frame layout: [0] start, [8:1] data, [9] parity, [10] stop
  assign rx_byte   = frame_q[8:1];
  assign frame_ok  = ~frame_q[0] & frame_q[10] &
                     ((CHECK_PARITY == 0) | (^frame_q[9:1]));
  assign is_prefix = (rx_byte == 8'hE0) | (rx_byte == 8'hF0);
  assign push_code = {acc_q[23:0], rx_byte};

  always_comb begin
    frame_d  = frame_q;
    bitcnt_d = bitcnt_q;
    idle_d   = idle_q;
    acc_d    = acc_q;
    err_d    = 1'b0;
    push     = 1'b0;
    if (bitcnt_q == 4'd11) begin
      bitcnt_d = '0;
      idle_d   = '0;
      if (!frame_ok) begin
        err_d = 1'b1;
        acc_d = '0;
      end else if (is_prefix) begin
        acc_d = {acc_q[23:0], rx_byte};
      end else begin
        push  = 1'b1;
        acc_d = '0;
      end
    end else if (bitcnt_q != 4'd0 && idle_q == TO_LIMIT) begin
      bitcnt_d = '0;
      idle_d   = '0;
      acc_d    = '0;
      err_d    = 1'b1;
    end else if (fall) begin
      frame_d  = {dt_s, frame_q[10:1]};
      bitcnt_d = bitcnt_q + 4'd1;
      idle_d   = '0;
    end else if (bitcnt_q != 4'd0) begin
      idle_d = idle_q + 1'b1;
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q     <= '0;
      bitcnt_q    <= '0;
      idle_q      <= '0;
      acc_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      bitcnt_q    <= bitcnt_d;
      idle_q      <= idle_d;
      acc_q       <= acc_d;
      frame_err_q <= err_d;
    end
  end

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = rd_en & (count_q != '0);
  assign wr   = push & (~full | pop);

  always_comb begin
    count_d = count_q + CW'(wr) - CW'(pop);
    ovf_d   = ovf_q;
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end else if (clr_errors) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= push_code;
  end

  assign code_valid = (count_q != '0);
  assign code       = code_valid ? mem_q[rptr_q] : 32'h0;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign frame_err  = frame_err_q;

endmodule
